// File: rtl/apb_wb_multibridge.sv
// apb_wb_multibridge: one APB3 slave port bridged to NUM_SLAVES pipelined
// Wishbone channels. The upper address bits select the channel.
//
// Ports:
//   clk, reset            - single clock, asynchronous active-high reset
//   apb_P*                - APB3 slave port; PADDR[SLAVE_AW+1:2] is the word
//                           address and PADDR[AW-1:SLAVE_AW+2] is the channel
//   wb_cyc/wb_stb         - one-hot per channel
//   wb_we/addr/wdata/sel  - shared request fields, held for the whole cycle
//   wb_ack/stall/err      - per-channel slave responses
//   wb_rdata              - channel i occupies [32i+31:32i]
//   busy                  - high whenever a transfer is in flight
module apb_wb_multibridge #(
    parameter int NUM_SLAVES = 2,
    parameter int SEL_BITS   = 1,
    parameter int SLAVE_AW   = 3,
    parameter int TIMEOUT    = 255,
    localparam int AW        = SLAVE_AW + SEL_BITS + 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AW-1:0]              apb_PADDR,
    input  logic                       apb_PSEL,
    input  logic                       apb_PENABLE,
    input  logic                       apb_PWRITE,
    input  logic [31:0]                apb_PWDATA,
    input  logic [3:0]                 apb_PSTRB,
    output logic                       apb_PREADY,
    output logic [31:0]                apb_PRDATA,
    output logic                       apb_PSLVERROR,
    output logic [NUM_SLAVES-1:0]      wb_cyc,
    output logic [NUM_SLAVES-1:0]      wb_stb,
    output logic                       wb_we,
    output logic [SLAVE_AW-1:0]        wb_addr,
    output logic [31:0]                wb_wdata,
    output logic [3:0]                 wb_sel,
    input  logic [NUM_SLAVES-1:0]      wb_ack,
    input  logic [NUM_SLAVES-1:0]      wb_stall,
    input  logic [NUM_SLAVES-1:0]      wb_err,
    input  logic [32*NUM_SLAVES-1:0]   wb_rdata,
    output logic                       busy
);
    localparam int NSLOT = 1 << SEL_BITS;
    localparam int CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [SEL_BITS-1:0]   idx_q, idx_d;
    logic                  dec_q, dec_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_SLAVES-1:0] cyc_q, cyc_d, stb_q, stb_d;
    logic                  we_q, we_d;
    logic [SLAVE_AW-1:0]   addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            sel_q, sel_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [31:0]           prdata_q, prdata_d;
    logic                  busy_q, busy_d;

    logic [SEL_BITS-1:0]   paddr_idx;
    logic                  idx_bad;
    logic [NUM_SLAVES-1:0] hit;
    logic [NSLOT-1:0]      stall_pad, ack_pad, err_pad;
    logic [31:0]           rdata_sel;
    logic                  s_stall, s_done, to_hit;
    logic                  unused_addr;

    assign paddr_idx   = apb_PADDR[AW-1:SLAVE_AW+2];
    assign idx_bad     = (32'(paddr_idx) >= NUM_SLAVES);
    assign unused_addr = ^apb_PADDR[1:0];

    // Pad per-channel inputs to the full index range so an out-of-range
    // index never selects past the vector.
    always_comb begin
        hit       = '0;
        stall_pad = '0;
        ack_pad   = '0;
        err_pad   = '0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit[i]       = (paddr_idx == SEL_BITS'(i));
            stall_pad[i] = wb_stall[i];
            ack_pad[i]   = wb_ack[i];
            err_pad[i]   = wb_err[i];
            if (idx_q == SEL_BITS'(i)) begin
                rdata_sel = wb_rdata[32*i +: 32];
            end
        end
    end

    assign s_stall = stall_pad[idx_q];
    assign s_done  = ack_pad[idx_q] | err_pad[idx_q];
    assign to_hit  = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dec_d     = dec_q;
        cnt_d     = cnt_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = prdata_q;

        case (state_q)
            IDLE: begin
                if (apb_PSEL && apb_PENABLE) begin
                    idx_d   = paddr_idx;
                    dec_d   = idx_bad;
                    cnt_d   = '0;
                    state_d = REQ;
                    if (!idx_bad) begin
                        we_d    = apb_PWRITE;
                        addr_d  = apb_PADDR[SLAVE_AW+1:2];
                        wdata_d = apb_PWDATA;
                        sel_d   = apb_PWRITE ? apb_PSTRB : 4'b1111;
                        cyc_d   = hit;
                        stb_d   = hit;
                    end
                end
            end
            REQ, WAIT: begin
                if (dec_q) begin
                    // Unmapped channel: error out without touching the bus.
                    state_d   = RESP;
                    pready_d  = apb_PSEL;
                    pslverr_d = apb_PSEL;
                    prdata_d  = '0;
                end else if ((state_q == WAIT || !s_stall) && s_done) begin
                    // A response while still stalled belongs to nothing.
                    cyc_d     = '0;
                    stb_d     = '0;
                    state_d   = RESP;
                    pready_d  = apb_PSEL;
                    pslverr_d = apb_PSEL & err_pad[idx_q];
                    prdata_d  = we_q ? '0 : rdata_sel;
                end else if (to_hit) begin
                    cyc_d     = '0;
                    stb_d     = '0;
                    state_d   = RESP;
                    pready_d  = apb_PSEL;
                    pslverr_d = apb_PSEL;
                    prdata_d  = '0;
                end else begin
                    if (TIMEOUT != 0) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (state_q == REQ && !s_stall) begin
                        stb_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            dec_q     <= 1'b0;
            cnt_q     <= '0;
            cyc_q     <= '0;
            stb_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dec_q     <= dec_d;
            cnt_q     <= cnt_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            busy_q    <= busy_d;
        end
    end

    assign apb_PREADY    = pready_q;
    assign apb_PSLVERROR = pslverr_q;
    assign apb_PRDATA    = prdata_q;
    assign wb_cyc        = cyc_q;
    assign wb_stb        = stb_q;
    assign wb_we         = we_q;
    assign wb_addr       = addr_q;
    assign wb_wdata      = wdata_q;
    assign wb_sel        = sel_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_apb_wb_multibridge.sv
// Directed bench for apb_wb_multibridge: 3 channels, 2 index bits,
// 3-bit word address, timeout of 8 cycles.
module tb_apb_wb_multibridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic [3:0]  pstrb = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [2:0]  cyc, stb;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [2:0]  ack = '0;
    logic [2:0]  stall = '0;
    logic [2:0]  err = '0;
    logic [95:0] rdata = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int acc0 = 0;

    apb_wb_multibridge #(
        .NUM_SLAVES(3),
        .SEL_BITS(2),
        .SLAVE_AW(3),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .apb_PADDR(paddr),
        .apb_PSEL(psel),
        .apb_PENABLE(penable),
        .apb_PWRITE(pwrite),
        .apb_PWDATA(pwdata),
        .apb_PSTRB(pstrb),
        .apb_PREADY(pready),
        .apb_PRDATA(prdata),
        .apb_PSLVERROR(pslverr),
        .wb_cyc(cyc),
        .wb_stb(stb),
        .wb_we(we),
        .wb_addr(addr),
        .wb_wdata(wdata),
        .wb_sel(sel),
        .wb_ack(ack),
        .wb_stall(stall),
        .wb_err(err),
        .wb_rdata(rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Accepted strobes on channel 0.
    always @(posedge clk) begin
        if (stb[0] && !stall[0]) acc0 <= acc0 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Setup phase, then access phase; returns at the negedge where
    // PENABLE goes high (the next posedge samples the access).
    task automatic apb_start(input logic [6:0] a, input logic w,
                             input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        psel    = 1'b1;
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        pstrb   = s;
        @(negedge clk);
        penable = 1'b1;
    endtask

    task automatic apb_end();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_cyc", 32'(cyc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_prdata", prdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Read channel 1, word 5.
        rdata[63:32] = 32'hDEADBEEF;
        apb_start(7'h34, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t1_stb", 32'(stb), 32'b010);
        chk("t1_cyc", 32'(cyc), 32'b010);
        chk("t1_addr", 32'(addr), 32'd5);
        chk("t1_we", 32'(we), 32'd0);
        chk("t1_sel", 32'(sel), 32'hF);
        chk("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_stb_drop", 32'(stb), 32'b000);
        chk("t1_cyc_hold", 32'(cyc), 32'b010);
        chk("t1_pready_early", 32'(pready), 32'd0);
        ack[1] = 1'b1;
        @(negedge clk);
        ack[1] = 1'b0;
        chk("t1_pready", 32'(pready), 32'd1);
        chk("t1_prdata", prdata, 32'hDEADBEEF);
        chk("t1_pslverr", 32'(pslverr), 32'd0);
        chk("t1_cyc_end", 32'(cyc), 32'b000);
        @(negedge clk);
        apb_end();
        chk("t1_pready_once", 32'(pready), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // Write channel 0 with stall held three cycles.
        stall[0] = 1'b1;
        apb_start(7'h08, 1'b1, 32'h11223344, 4'b0101);
        @(negedge clk);
        chk("t2_stb1", 32'(stb), 32'b001);
        chk("t2_sel", 32'(sel), 32'b0101);
        chk("t2_we", 32'(we), 32'd1);
        chk("t2_wdata", wdata, 32'h11223344);
        chk("t2_addr", 32'(addr), 32'd2);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        chk("t2_stb2", 32'(stb), 32'b001);
        chk("t2_ack_ignored", 32'(pready), 32'd0);
        @(negedge clk);
        chk("t2_stb3", 32'(stb), 32'b001);
        @(negedge clk);
        chk("t2_stb4", 32'(stb), 32'b001);
        stall[0] = 1'b0;
        @(negedge clk);
        chk("t2_stb_drop", 32'(stb), 32'b000);
        chk("t2_cyc_hold", 32'(cyc), 32'b001);
        chk("t2_sel_hold", 32'(sel), 32'b0101);
        chk("t2_pready_early", 32'(pready), 32'd0);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        chk("t2_pready", 32'(pready), 32'd1);
        chk("t2_pslverr", 32'(pslverr), 32'd0);
        chk("t2_prdata", prdata, 32'd0);
        chk("t2_accepts", 32'(acc0), 32'd1);
        @(negedge clk);
        apb_end();
        chk("t2_idle", 32'(busy), 32'd0);

        // Error on a write to channel 2, then a clean read of channel 1.
        apb_start(7'h40, 1'b1, 32'hA5A5A5A5, 4'hF);
        @(negedge clk);
        chk("t3_stb", 32'(stb), 32'b100);
        @(negedge clk);
        err[2] = 1'b1;
        @(negedge clk);
        err[2] = 1'b0;
        chk("t3_pready", 32'(pready), 32'd1);
        chk("t3_pslverr", 32'(pslverr), 32'd1);
        @(negedge clk);
        apb_end();
        rdata[63:32] = 32'hCAFEF00D;
        apb_start(7'h20, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t3r_stb", 32'(stb), 32'b010);
        @(negedge clk);
        ack[1] = 1'b1;
        @(negedge clk);
        ack[1] = 1'b0;
        chk("t3r_pready", 32'(pready), 32'd1);
        chk("t3r_pslverr", 32'(pslverr), 32'd0);
        chk("t3r_prdata", prdata, 32'hCAFEF00D);
        @(negedge clk);
        apb_end();

        // Channel 0 never answers: timeout after 8 cycles.
        apb_start(7'h0C, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t4_cyc_start", 32'(cyc), 32'b001);
        repeat (7) @(negedge clk);
        chk("t4_cyc_last", 32'(cyc), 32'b001);
        chk("t4_pready_early", 32'(pready), 32'd0);
        @(negedge clk);
        chk("t4_cyc_drop", 32'(cyc), 32'b000);
        chk("t4_pready", 32'(pready), 32'd1);
        chk("t4_pslverr", 32'(pslverr), 32'd1);
        chk("t4_prdata", prdata, 32'd0);
        ack[0] = 1'b1;
        rdata[31:0] = 32'h55555555;
        @(negedge clk);
        apb_end();
        @(negedge clk);
        ack[0] = 1'b0;
        chk("t4_late_busy", 32'(busy), 32'd0);
        chk("t4_late_cyc", 32'(cyc), 32'b000);
        chk("t4_late_pready", 32'(pready), 32'd0);
        chk("t4_late_prdata", prdata, 32'd0);

        // Unmapped channel index 3.
        apb_start(7'h60, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t5_cyc", 32'(cyc), 32'b000);
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_pready_early", 32'(pready), 32'd0);
        @(negedge clk);
        chk("t5_pready", 32'(pready), 32'd1);
        chk("t5_pslverr", 32'(pslverr), 32'd1);
        chk("t5_cyc2", 32'(cyc), 32'b000);
        @(negedge clk);
        apb_end();
        chk("t5_idle", 32'(busy), 32'd0);

        // Reset asserted while waiting on channel 1.
        apb_start(7'h24, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t6_addr", 32'(addr), 32'd1);
        @(negedge clk);
        chk("t6_wait_cyc", 32'(cyc), 32'b010);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_cyc", 32'(cyc), 32'b000);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_sel", 32'(sel), 32'd0);
        chk("t6_rst_addr", 32'(addr), 32'd0);
        @(negedge clk);
        apb_end();
        ack[1] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ack[1] = 1'b0;
        chk("t6_post_busy", 32'(busy), 32'd0);
        chk("t6_post_cyc", 32'(cyc), 32'b000);
        chk("t6_post_pready", 32'(pready), 32'd0);

        // Read with ack in the acceptance cycle.
        rdata[31:0] = 32'h0BADF00D;
        apb_start(7'h1C, 1'b0, 32'h0, 4'h0);
        @(negedge clk);
        chk("t7_stb", 32'(stb), 32'b001);
        chk("t7_addr", 32'(addr), 32'd7);
        ack[0] = 1'b1;
        @(negedge clk);
        ack[0] = 1'b0;
        chk("t7_pready", 32'(pready), 32'd1);
        chk("t7_prdata", prdata, 32'h0BADF00D);
        chk("t7_pslverr", 32'(pslverr), 32'd0);
        chk("t7_cyc", 32'(cyc), 32'b000);
        @(negedge clk);
        apb_end();
        chk("t7_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_wb_multibridge.md
Name: apb_wb_multibridge

Overview:
- Parametrised APB3-to-Wishbone (pipelined) bridge that fans one APB slave port out to NUM_SLAVES Wishbone peripherals, such as SD, UART and timer cores, decoded by address.
- Replaces per-peripheral ad-hoc single-strobe glue.
- Adds PSTRB byte selects, Wishbone stall/err handling, a bus-hang timeout, and decode errors.

Parameters:
- NUM_SLAVES, 2, number of Wishbone channels (1..16).
- SEL_BITS, 1, address bits used for slave index; requires 2**SEL_BITS >= NUM_SLAVES.
- SLAVE_AW, 3, Wishbone word-address width per slave.
- TIMEOUT, 255, cycles from strobe to forced error; 0 disables the timeout.
- Derived: AW = SLAVE_AW+SEL_BITS+2.

Ports:
- clk  in  1  single clock domain.
- reset  in  1  asynchronous, active-high.
- apb_PADDR  in  AW  byte address; [SLAVE_AW+1:2] is the word address, [AW-1:SLAVE_AW+2] is the slave index.
- apb_PSEL, apb_PENABLE, apb_PWRITE  in  1 each.
- apb_PWDATA  in  32.
- apb_PSTRB  in  4.
- apb_PREADY  out  1.
- apb_PRDATA  out  32.
- apb_PSLVERROR  out  1.
- wb_cyc, wb_stb  out  NUM_SLAVES each  one-hot per slave.
- wb_we  out  1.
- wb_addr  out  SLAVE_AW.
- wb_wdata  out  32.
- wb_sel  out  4.
- wb_ack, wb_stall, wb_err  in  NUM_SLAVES each.
- wb_rdata  in  32*NUM_SLAVES  slave i occupies [32i+31:32i].
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (async): FSM=IDLE; all outputs 0, including PRDATA, wb_cyc/stb, and timeout counter. Wishbone inputs arriving after reset are ignored.
- FSM states: IDLE, REQ, WAIT, RESP. One transfer at a time; all outputs registered.
- IDLE, on PSEL&PENABLE:
  - Latch address, PWDATA, PWRITE and index idx.
  - wb_sel = PSTRB on writes, 4'b1111 on reads.
  - If idx >= NUM_SLAVES, go to RESP with err=1 and PRDATA=0; no Wishbone activity.
  - Otherwise go to REQ, asserting wb_cyc[idx]=wb_stb[idx]=1 from the next cycle.
- REQ:
  - stb stays high while wb_stall[idx]=1.
  - On the first cycle with stall=0 the strobe is accepted; stb drops next cycle and the FSM goes to WAIT.
  - ack/err in the accept cycle is honoured, going directly to RESP.
- WAIT: cyc stays high until wb_ack[idx] or wb_err[idx]; ack/err before acceptance is ignored.
- On ack/err:
  - Latch PRDATA = wb_rdata slice on reads, 0 on writes.
  - Latch err = wb_err[idx].
  - Drop cyc next cycle and go to RESP.
- Timeout: counter clears on REQ entry and increments each REQ/WAIT cycle. When it reaches TIMEOUT:
  - Drop cyc/stb.
  - RESP with err=1, PRDATA=0.
  - ack/err in the same cycle as the timeout wins over the timeout.
- RESP:
  - PREADY=1 and PSLVERROR=err for exactly one cycle, gated by PSEL.
  - If PSEL has dropped (protocol violation), the response is silently discarded.
  - Then IDLE; PRDATA holds its value until the next RESP.
- No re-trigger: the cycle after RESP is IDLE. The APB setup phase (PENABLE=0) prevents double issue, so each access issues exactly one strobe.
- Latency (access phase at cycle T, no stall, ack 1 cycle after stb):
  - stb at T+1, ack at T+2, PREADY at T+3.
  - Decode error: PREADY at T+2.
- wb_we, wb_addr, wb_wdata and wb_sel are stable for the whole cyc window.

Test Plan:
- Read slave 1, addr 0x14: stb only on channel 1 with wb_addr=5; ack+rdata 0xDEADBEEF at T+2 -> PREADY at T+3, PRDATA=0xDEADBEEF, PSLVERROR=0.
- Write PSTRB=4'b0101, PWDATA=0x11223344 to slave 0 with stall held 3 cycles -> stb high 4 cycles, wb_sel=0101, exactly one accepted strobe, PREADY one cycle after ack.
- wb_err on write -> PREADY with PSLVERROR=1; next read to the other slave completes normally with PSLVERROR=0.
- TIMEOUT=8, slave never acks -> cyc drops 8 cycles after REQ entry; PREADY with PSLVERROR=1, PRDATA=0; late ack afterwards ignored and busy=0.
- NUM_SLAVES=3, SEL_BITS=2, access index 3 -> no wb_cyc asserted; PREADY at T+2 with PSLVERROR=1.
- Assert reset while in WAIT -> all outputs 0 immediately, without waiting for a clk edge; subsequent ack ignored; next APB read completes normally.
